// File: rtl/modinv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : modinv_unit (with modred_multiplier)
//  Function : Modular inverse a^(Q-2) mod Q by square-and-multiply.
//  Revision : 1.0
// ============================================================================

module modred_multiplier #(
  parameter int          LOGQ = 17,
  parameter int unsigned Q    = 65537
) (
  input  logic [LOGQ-1:0] x,
  input  logic [LOGQ-1:0] y,
  output logic [LOGQ-1:0] p
);
  localparam logic [2*LOGQ-1:0] c_q = (2*LOGQ)'(Q);

  logic [2*LOGQ-1:0] w_prod;

  assign w_prod = (2*LOGQ)'(x) * (2*LOGQ)'(y);
  // Operands are < Q, so the remainder always fits in LOGQ bits.
  assign p      = LOGQ'(w_prod % c_q);
endmodule

module modinv_unit #(
  parameter int          LOGQ = 17,
  parameter int unsigned Q    = 65537
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] inv,
  output logic            err
);
  localparam int            IW  = $clog2(LOGQ);
  localparam logic [LOGQ-1:0] c_e = LOGQ'(Q - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state, w_next;
  logic [LOGQ-1:0] r_acc, r_base, r_inv;
  logic [IW-1:0]   r_idx;
  logic            r_err, r_out_valid;
  logic [LOGQ-1:0] w_opb, w_red;

  assign w_opb = (r_state == S_MUL) ? r_base : r_acc;

  modred_multiplier #(.LOGQ(LOGQ), .Q(Q)) u_mul (
    .x (r_acc),
    .y (w_opb),
    .p (w_red)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_SQR;
      S_SQR: begin
        if (c_e[r_idx])          w_next = S_MUL;
        else if (r_idx == '0)    w_next = S_DONE;
      end
      S_MUL:  w_next = (r_idx == '0) ? S_DONE : S_SQR;
      S_DONE: if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_base      <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_inv       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_base <= a;
          r_acc  <= LOGQ'(1);
          r_idx  <= IW'(LOGQ - 1);
          r_err  <= (a == '0);
        end
        S_SQR: begin
          r_acc <= w_red;
          // The index only advances here when no multiply follows this bit.
          if (!c_e[r_idx] && r_idx != '0) r_idx <= r_idx - 1'b1;
        end
        S_MUL: begin
          r_acc <= w_red;
          if (r_idx != '0) r_idx <= r_idx - 1'b1;
        end
        S_DONE: begin
          // First DONE cycle loads the output register; result then holds until taken.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_inv       <= r_acc;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign inv       = r_inv;
  assign err       = r_err;
endmodule

`default_nettype wire

// File: tb/tb_modinv_unit.sv
`default_nettype none
// Scoreboard bench for modinv_unit: driver pushes expectations, monitor pops on output.
`timescale 1ns/1ps
module tb_modinv_unit;
  localparam int          LOGQ = 17;
  localparam int unsigned Q    = 65537;
  localparam int          LAT  = 34;

  logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [LOGQ-1:0] a = '0;
  logic            in_ready, out_valid, err;
  logic [LOGQ-1:0] inv;

  modinv_unit #(.LOGQ(LOGQ), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .inv(inv), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LOGQ-1:0] op;
    logic [LOGQ-1:0] inv;
    logic            err;
    int              t;
  } exp_t;

  exp_t            q[$];
  int              errors = 0, checks = 0, cyc = 0, stall_n = 0, stall_left = 0;
  bit              bp = 1'b0, seen = 1'b0;
  logic [LOGQ-1:0] h_inv;
  logic            h_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [LOGQ-1:0] ref_inv(input logic [LOGQ-1:0] x);
    longint r = 1, b = x, e = Q - 2;
    if (x == '0) return '0;
    while (e != 0) begin
      if (e[0]) r = (r * b) % Q;
      b = (b * b) % Q;
      e = e >> 1;
    end
    return LOGQ'(r);
  endfunction

  // Monitor: owns out_ready, checks latency, hold stability and results in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      out_ready = 1'b0;
      seen      = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen       = 1'b1;
        h_inv      = inv;
        h_err      = err;
        stall_left = stall_n;
        if (q.size() == 0) chk("unexpected_output", 1'b0, inv, -1);
        else chk("latency", (cyc - q[0].t) == LAT, cyc - q[0].t, LAT);
      end else begin
        chk("hold_inv", inv == h_inv, inv, h_inv);
        chk("hold_err", err == h_err, err, h_err);
        chk("in_ready_busy", in_ready == 1'b0, in_ready, 0);
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("inv", inv == e.inv, inv, e.inv);
        chk("err", err == e.err, err, e.err);
        if (!e.err) chk("inv_times_a", ((longint'(inv) * e.op) % Q) == 1,
                        (longint'(inv) * e.op) % Q, 1);
        seen = 1'b0;
      end
    end else begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [LOGQ-1:0] op, input logic [LOGQ-1:0] ex, input logic ee);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a        = op;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1'b0, n, 500);
    end else begin
      e.op = op; e.inv = ex; e.err = ee; e.t = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a        = LOGQ'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 1'b0, q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit ov;
    logic [LOGQ-1:0] x;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready == 1'b1, in_ready, 1);
    chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("rst_inv", inv == '0, inv, 0);
    chk("rst_err", err == 1'b0, err, 0);
    rst_n = 1'b1;

    send(17'd1, 17'd1, 1'b0);
    send(17'd2, 17'd32769, 1'b0);
    send(17'd3, 17'd21846, 1'b0);
    send(17'd65536, 17'd65536, 1'b0);
    send(17'd0, 17'd0, 1'b1);
    drain();

    // 4 * 49153 = 196612 = 3*65537 + 1; result held five cycles before acceptance
    stall_n = 5;
    send(17'd4, 17'd49153, 1'b0);
    drain();
    stall_n = 0;

    send(17'd9, ref_inv(17'd9), 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_abort", in_ready == 1'b1, in_ready, 1);
    ov = 1'b0;
    repeat (40) begin
      @(negedge clk);
      ov |= out_valid;
    end
    chk("no_result_after_abort", ov == 1'b0, ov, 0);
    // 5 * 26215 = 131075 = 2*65537 + 1
    send(17'd5, 17'd26215, 1'b0);
    drain();

    bp = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      x = LOGQ'($urandom_range(1, Q - 1));
      send(x, ref_inv(x), 1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
